// File: rtl/step_sequencer_if.sv
// Avalon-MM slave bus bundle for the step sequencer register file.
interface step_sequencer_if;
  logic        chipselect;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (output chipselect, output address, output write, output writedata,
                  output read, input readdata);
  modport slave  (input chipselect, input address, input write, input writedata,
                  input read, output readdata);
endinterface

// File: rtl/step_sequencer.sv
// Stepper-motor phase sequencer: each synchronised step_clk rise advances a 4-coil pattern,
// counting down a programmed step budget and tracking absolute half-step position.
module step_sequencer #(
  parameter int STEP_W  = 16,
  parameter bit HOLD_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   step_clk,
  step_sequencer_if.slave        bus,
  output logic [3:0]             coils,
  output logic                   irq
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_ZERO = STEP_W'(0);

  state_t             state_q;
  logic               sync1_q, sync2_q, sync3_q, tick_q;
  logic [2:0]         phase_q, phase_d;
  logic [31:0]        pos_q, pos_d;
  logic [STEP_W-1:0]  steps_q, remaining_q;
  logic               dir_q, half_q, irq_en_q, done_q, aborted_q;
  logic [3:0]         coils_q;
  logic               irq_q;
  logic [31:0]        readdata_q, rdata_s;
  logic               wr_ctrl_s, wr_steps_s, wr_stat_s, wr_pos_s, rd_s, go_s, stop_s;

  function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
    logic [3:0] pat;
    case (idx)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      3'd7:    pat = 4'b1001;
      default: pat = 4'b0000;
    endcase
    return pat;
  endfunction

  // Bus decode, next phase/position and read-data mux.
  always_comb begin
    wr_ctrl_s  = bus.chipselect & bus.write & (bus.address == 2'd0);
    wr_steps_s = bus.chipselect & bus.write & (bus.address == 2'd1);
    wr_stat_s  = bus.chipselect & bus.write & (bus.address == 2'd2);
    wr_pos_s   = bus.chipselect & bus.write & (bus.address == 2'd3);
    rd_s       = bus.chipselect & bus.read;
    stop_s     = wr_ctrl_s & bus.writedata[3];
    go_s       = wr_ctrl_s & bus.writedata[0] & ~bus.writedata[3];

    if (dir_q) begin
      phase_d = phase_q + (half_q ? 3'd1 : 3'd2);
      pos_d   = pos_q + (half_q ? 32'd1 : 32'd2);
    end else begin
      phase_d = phase_q - (half_q ? 3'd1 : 3'd2);
      pos_d   = pos_q - (half_q ? 32'd1 : 32'd2);
    end

    rdata_s = 32'd0;
    case (bus.address)
      2'd0:    rdata_s = {27'd0, irq_en_q, 1'b0, half_q, dir_q, 1'b0};
      2'd1:    rdata_s[STEP_W-1:0] = steps_q;
      2'd2: begin
        rdata_s[16 +: STEP_W] = remaining_q;
        rdata_s[2:0]          = {aborted_q, done_q, (state_q == RUN)};
      end
      2'd3:    rdata_s = pos_q;
      default: rdata_s = 32'd0;
    endcase
  end

  // step_clk synchroniser; tick_q is registered so coils move 3 edges after first sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= step_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      tick_q  <= sync2_q & ~sync3_q;
    end
  end

  // Control FSM, register file and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= 3'd0;
      pos_q       <= 32'd0;
      steps_q     <= STEP_ZERO;
      remaining_q <= STEP_ZERO;
      dir_q       <= 1'b0;
      half_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      coils_q     <= 4'b0000;
      irq_q       <= 1'b0;
      readdata_q  <= 32'd0;
    end else begin
      irq_q <= done_q & irq_en_q;
      if (rd_s) begin
        readdata_q <= rdata_s;
      end
      // Clears come first so a done set later in this block overrides them.
      if (wr_stat_s && bus.writedata[1]) begin
        done_q <= 1'b0;
      end
      if (wr_stat_s && bus.writedata[2]) begin
        aborted_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (wr_steps_s) begin
            steps_q <= bus.writedata[STEP_W-1:0];
          end
          if (wr_pos_s) begin
            pos_q <= bus.writedata;
          end
          if (go_s) begin
            dir_q    <= bus.writedata[1];
            half_q   <= bus.writedata[2];
            irq_en_q <= bus.writedata[4];
            if (steps_q != STEP_ZERO) begin
              state_q     <= RUN;
              remaining_q <= steps_q;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop_s) begin
            state_q     <= IDLE;
            remaining_q <= STEP_ZERO;
            aborted_q   <= 1'b1;
            if (!HOLD_EN) begin
              coils_q <= 4'b0000;
            end
          end else if (tick_q) begin
            phase_q     <= phase_d;
            pos_q       <= pos_d;
            remaining_q <= remaining_q - STEP_ONE;
            if (remaining_q == STEP_ONE) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              coils_q <= HOLD_EN ? phase_pattern(phase_d) : 4'b0000;
            end else begin
              coils_q <= phase_pattern(phase_d);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign coils        = coils_q;
  assign irq          = irq_q;
  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: vector table plus hand-written corner sequences.
module tb_step_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        step_clk = 1'b0;
  logic        sel = 1'b0;
  logic        cs = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  coils0, coils1;
  logic        irq0, irq1;
  int          checks = 0;
  int          failures = 0;

  step_sequencer_if bus0 ();
  step_sequencer_if bus1 ();

  assign bus0.chipselect = cs & ~sel;
  assign bus1.chipselect = cs & sel;
  assign bus0.address = addr;   assign bus1.address = addr;
  assign bus0.write = wr;       assign bus1.write = wr;
  assign bus0.read = rd;        assign bus1.read = rd;
  assign bus0.writedata = wdata; assign bus1.writedata = wdata;

  step_sequencer #(.STEP_W(16), .HOLD_EN(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .step_clk(step_clk), .bus(bus0), .coils(coils0), .irq(irq0));
  step_sequencer #(.STEP_W(16), .HOLD_EN(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .step_clk(step_clk), .bus(bus1), .coils(coils1), .irq(irq1));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] exp; string name; } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [15:0] steps; logic [4:0] ctrl; int nticks; logic [31:0] pos0;
    logic [3:0] exp_coils; logic [31:0] exp_pos; logic [31:0] exp_stat;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0; step_clk = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk); cs = 1'b0; wr = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    sb_t item;
    sb_q.push_back('{exp: exp, name: name});
    @(negedge clk); cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk); cs = 1'b0; rd = 1'b0;
    item = sb_q.pop_front();
    check(item.name, sel ? bus1.readdata : bus0.readdata, item.exp);
  endtask

  task automatic tick();
    @(negedge clk); step_clk = 1'b1;
    repeat (2) @(negedge clk);
    step_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{16'd4, 5'h07, 4, 32'd0,          4'b0010, 32'd4,          32'h0000_0002};
    vecs[1] = '{16'd3, 5'h01, 3, 32'd0,          4'b0100, 32'hFFFF_FFFA,  32'h0000_0002};
    vecs[2] = '{16'd5, 5'h03, 5, 32'd100,        4'b0100, 32'd110,        32'h0000_0002};
    vecs[3] = '{16'd9, 5'h05, 9, 32'd0,          4'b1001, 32'hFFFF_FFF7,  32'h0000_0002};
    vecs[4] = '{16'd6, 5'h07, 3, 32'd0,          4'b0110, 32'd3,          32'h0003_0001};
    vecs[5] = '{16'd1, 5'h17, 1, 32'h7FFF_FFFF,  4'b1100, 32'h8000_0000,  32'h0000_0002};

    do_reset();
    check("reset_coils", {28'd0, coils0}, 32'd0);
    check("reset_irq", {31'd0, irq0}, 32'd0);
    check("reset_readdata", bus0.readdata, 32'd0);
    do_read(2'd2, 32'd0, "reset_stat");
    do_read(2'd3, 32'd0, "reset_pos");
    do_read(2'd1, 32'd0, "reset_steps");

    for (int v = 0; v < 6; v++) begin
      do_reset();
      do_write(2'd3, vecs[v].pos0);
      do_write(2'd1, {16'd0, vecs[v].steps});
      do_write(2'd0, {27'd0, vecs[v].ctrl});
      for (int t = 0; t < vecs[v].nticks; t++) tick();
      check($sformatf("vec%0d_coils", v), {28'd0, coils0}, {28'd0, vecs[v].exp_coils});
      do_read(2'd3, vecs[v].exp_pos, $sformatf("vec%0d_pos", v));
      do_read(2'd2, vecs[v].exp_stat, $sformatf("vec%0d_stat", v));
      do_read(2'd0, {27'd0, vecs[v].ctrl & 5'b10110}, $sformatf("vec%0d_ctrl", v));
    end

    // Stop mid-move, then go+stop together in IDLE, then clear aborted.
    do_reset();
    do_write(2'd1, 32'd10);
    do_write(2'd0, 32'h07);
    tick(); tick();
    do_write(2'd0, 32'h08);
    do_read(2'd2, 32'h0000_0004, "stop_stat");
    tick();
    check("stop_coils_hold", {28'd0, coils0}, 32'h4);
    do_read(2'd3, 32'd2, "stop_pos");
    do_write(2'd0, 32'h0F);
    do_read(2'd2, 32'h0000_0004, "gostop_stat");
    do_write(2'd2, 32'h4);
    do_read(2'd2, 32'h0000_0000, "clear_aborted");

    // go with STEPS==0: done at once, irq one clock later, cleared by STAT write.
    do_reset();
    do_write(2'd0, 32'h11);
    check("zero_irq_early", {31'd0, irq0}, 32'd0);
    @(negedge clk);
    check("zero_irq_set", {31'd0, irq0}, 32'd1);
    check("zero_coils", {28'd0, coils0}, 32'd0);
    do_read(2'd2, 32'h0000_0002, "zero_stat");
    do_write(2'd2, 32'h2);
    check("irq_hold_one", {31'd0, irq0}, 32'd1);
    @(negedge clk);
    check("irq_cleared", {31'd0, irq0}, 32'd0);

    // Writes while busy are ignored.
    do_reset();
    do_write(2'd1, 32'd6);
    do_write(2'd0, 32'h07);
    tick();
    do_write(2'd1, 32'd1);
    do_read(2'd1, 32'd6, "busy_steps_ignored");
    do_write(2'd3, 32'd1234);
    do_read(2'd3, 32'd1, "busy_pos_ignored");
    do_write(2'd0, 32'h01);
    do_read(2'd0, 32'h06, "busy_go_ignored");
    tick();
    check("busy_coils", {28'd0, coils0}, 32'h4);
    do_read(2'd2, 32'h0004_0001, "busy_stat");

    // Asynchronous step_clk rise: coils move exactly three edges after first sample.
    do_reset();
    do_write(2'd1, 32'd2);
    do_write(2'd0, 32'h07);
    @(posedge clk); #3 step_clk = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("lat_edge%0d", e), {28'd0, coils0}, 32'd0);
    end
    @(posedge clk); @(negedge clk);
    check("lat_edge3", {28'd0, coils0}, 32'hC);
    repeat (6) @(negedge clk);
    check("single_step", {28'd0, coils0}, 32'hC);
    step_clk = 1'b0;
    repeat (4) @(negedge clk);

    // Asynchronous reset mid-move.
    do_reset();
    do_write(2'd1, 32'd10);
    do_write(2'd0, 32'h07);
    tick(); tick();
    @(negedge clk); #2 reset_n = 1'b0;
    #1 check("async_rst_coils", {28'd0, coils0}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    do_read(2'd2, 32'd0, "async_rst_stat");
    do_read(2'd3, 32'd0, "async_rst_pos");

    // Non-holding instance de-energises coils on finish.
    do_reset();
    sel = 1'b1;
    do_write(2'd1, 32'd2);
    do_write(2'd0, 32'h07);
    tick();
    check("nohold_mid", {28'd0, coils1}, 32'hC);
    tick();
    check("nohold_done", {28'd0, coils1}, 32'd0);
    do_read(2'd2, 32'h0000_0002, "nohold_stat");
    do_read(2'd3, 32'd2, "nohold_pos");
    sel = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
